// File: rtl/counter_arbiter_pkg.sv
// counter_arbiter_pkg: shared FSM state type and default counter geometry.
package counter_arbiter_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LO    = 3;
    localparam int DEF_HI    = 15;

endpackage

// File: rtl/ud_step_core.sv
// ud_step_core: next value of a LO..HI wrapping up/down counter.
// COUNTER_ARBITER_WRAP_EN adds the wrap flag output.
module ud_step_core
    import counter_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LO    = DEF_LO,
    parameter int HI    = DEF_HI
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] next
`ifdef COUNTER_ARBITER_WRAP_EN
    ,
    output logic             wrap
`endif
);

    localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

    logic at_edge;

    always_comb begin
        at_edge = dir ? count == HI_V : count == LO_V;
        next    = at_edge ? (dir ? LO_V : HI_V) : (dir ? count + WIDTH'(1) : count - WIDTH'(1));
`ifdef COUNTER_ARBITER_WRAP_EN
        wrap    = at_edge;
`endif
    end

endmodule

// File: rtl/counter_arbiter_ctrl.sv
// counter_arbiter_ctrl: round-robin two-requester burst controller for a LO..HI wrapping counter.
// Define COUNTER_ARBITER_WRAP_EN to add the registered wrap pulse output.
module counter_arbiter_ctrl
    import counter_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LO    = DEF_LO,
    parameter int HI    = DEF_HI
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [1:0]      dir,
    input  logic [1:0][2:0] len,
    output logic [1:0]      ack,
    output logic            done,
    output logic            busy,
    output logic [WIDTH-1:0] count
`ifdef COUNTER_ARBITER_WRAP_EN
    ,
    output logic            wrap
`endif
);

    state_t           state_q, state_d;
    logic             last_q, dir_q, grant, win, step, step_dir;
    logic [2:0]       rem_q, glen;
    logic [WIDTH-1:0] next_count;
`ifdef COUNTER_ARBITER_WRAP_EN
    logic             step_wrap;
`endif

    ud_step_core #(.WIDTH(WIDTH), .LO(LO), .HI(HI)) u_step (
        .count (count),
        .dir   (step_dir),
        .next  (next_count)
`ifdef COUNTER_ARBITER_WRAP_EN
        ,
        .wrap  (step_wrap)
`endif
    );

    // The first step lands on the grant edge; RUN then holds len cycles, the last showing the final value.
    always_comb begin
        busy     = state_q == RUN;
        grant    = !rst && state_q == IDLE && |req;
        win      = &req ? ~last_q : req[1];
        glen     = len[win];
        ack      = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
        step     = grant ? glen != 3'd0 : busy && rem_q > 3'd1;
        step_dir = grant ? dir[win] : dir_q;
        done     = grant ? glen == 3'd0 : busy && rem_q == 3'd1;
        state_d  = (grant && glen != 3'd0) ? RUN : (busy && rem_q == 3'd1) ? IDLE : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count   <= WIDTH'(LO);
            last_q  <= 1'b1;
            dir_q   <= 1'b0;
            rem_q   <= 3'd0;
`ifdef COUNTER_ARBITER_WRAP_EN
            wrap    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_q <= win;
                dir_q  <= dir[win];
                rem_q  <= glen;
            end else if (busy) begin
                rem_q  <= rem_q - 3'd1;
            end
            if (step)
                count <= next_count;
`ifdef COUNTER_ARBITER_WRAP_EN
            wrap    <= step && step_wrap;
`endif
        end
    end

endmodule

// File: doc/counter_arbiter_ctrl.md
COUNTER_ARBITER_CTRL -- requirements
Module: counter_arbiter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter LO, default 3, lower bound of count range.
REQ-003 Parameter HI, default 15, upper bound of count range (LO < HI <= 2^WIDTH-1).
REQ-004 Port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  2  per-requester request, held high until its ack.
REQ-007 Port dir  input  2  per-requester direction, 1 = up, 0 = down.
REQ-008 Port len  input  2x3  per-requester step count, 0..7.
REQ-009 Port ack  output  2  one-cycle acceptance pulse, per requester.
REQ-010 Port done  output  1  one-cycle pulse on the last step of a burst.
REQ-011 Port busy  output  1  high while a burst executes.
REQ-012 Port count  output  WIDTH  current counter value.

Function
REQ-013 FSM states IDLE, RUN; IDLE is the reset state.
REQ-014 In IDLE with any req high, arbitrate round-robin: grant the requester not granted last; on tie after reset, requester 0 wins.
REQ-015 Grant: ack of winner high for exactly one cycle; dir and len latched in that same cycle.
REQ-016 Latched len = 0: ack only, no step, done pulses the same cycle, FSM stays IDLE.
REQ-017 Latched len > 0: FSM enters RUN next cycle; busy high for exactly len cycles.
REQ-018 In RUN, count moves one step per cycle in the latched direction; requester dir/len changes are ignored.
REQ-019 Up step: count == HI -> LO; else count + 1.
REQ-020 Down step: count == LO -> HI; else count - 1.
REQ-021 done pulses in the cycle of the final step; FSM returns to IDLE the next cycle.
REQ-022 No arbitration while busy; pending req waits; earliest new ack is the first cycle back in IDLE.
REQ-023 Count outside LO..HI is unreachable; no other path writes count.
REQ-024 Grant-to-first-step latency is one cycle.

Reset
REQ-025 rst high asynchronously forces: count = LO, FSM = IDLE, ack = 0, done = 0, busy = 0, round-robin pointer = requester 1 (so requester 0 wins first).
REQ-026 rst mid-burst aborts the burst immediately; no done pulse; the requester is not re-acked unless it re-requests.

Configuration
REQ-027 Macro COUNTER_ARBITER_WRAP_EN present: extra output wrap (1 bit) pulses in each cycle a step crosses HI->LO or LO->HI; reset value 0.
REQ-028 Macro absent: no wrap port, no wrap logic; all other behaviour identical.

Structure
REQ-029 Shared package counter_arbiter_pkg holds the FSM state enum and the default LO/HI/WIDTH constants.
REQ-030 Sub-module ud_step_core: combinational next-value function (count, dir, LO, HI) -> next count and wrap flag; instantiated once.

Verification
REQ-031 Reset: assert rst asynchronously mid-cycle -> count=3, busy=0, ack=0 immediately.
REQ-032 Up wrap: count=14, req0, dir=1, len=3 -> ack0 pulse; count 15, 3, 4 over three cycles; done with 4; wrap pulse on 15->3 (macro on).
REQ-033 Down wrap: count=4, req1, dir=0, len=2 -> count 3, 15; done on second step.
REQ-034 Contention: req0 and req1 both high after reset, each len=1 -> ack0 first, ack1 in the first IDLE cycle after done; no overlap of busy.
REQ-035 Zero length: req0, len=0 -> ack0 and done in the same cycle, busy stays 0, count unchanged.
REQ-036 Abort: rst during RUN with len=7 after 2 steps -> count=3, no done, FSM IDLE.
